// File: rtl/seq_game_pkg.sv
// Shared types and helpers for the sequence-memory game engine.
package seq_game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SHOW_ON,
        SHOW_OFF,
        WAIT,
        WIN,
        LOSE
    } game_state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Two-digit BCD increment that sticks at 99 once the display is full.
    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99)
            r = v;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/game_lfsr.sv
// 16-bit right-shifting Galois LFSR; exposes only the low bits the game consumes.
module game_lfsr
    import seq_game_pkg::*;
#(
    parameter int p_out = 2
) (
    input  logic             clk,
    input  logic             load,
    input  logic [15:0]      seed,
    input  logic             en,
    output logic [p_out-1:0] rnd
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (load)
            lfsr_q <= seed;
        else if (en)
            lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    end

    assign rnd = lfsr_q[p_out-1:0];

endmodule

// File: rtl/seq_game_engine.sv
// Sequence-memory game: fills a random key sequence, plays it back round by round
// and checks the player's presses against it under a per-press time limit.
module seq_game_engine
    import seq_game_pkg::*;
#(
    parameter int          p_key   = 4,
    parameter int          p_depth = 16,
    parameter int          p_tick  = 50_000_000,
    parameter int          p_time  = 5,
    parameter logic [15:0] p_seed  = 16'hACE1
) (
    input  logic                         CLOCK_50,
    input  logic                         R,
    input  logic                         start,
    input  logic [1:0]                   speed,
    input  logic [p_key-1:0]             KEY,
    output logic [p_key-1:0]             leds,
    output logic [$clog2(p_depth+1)-1:0] ROUND,
    output logic [7:0]                   POINTS,
    output logic [3:0]                   TIME,
    output logic                         end_FPGA,
    output logic                         end_User,
    output logic                         match,
    output logic                         end_time,
    output logic                         win,
    output logic                         busy
);

    localparam int KW = $clog2(p_key);
    localparam int AW = $clog2(p_depth);
    localparam int IW = $clog2(p_depth + 1);
    localparam int CW = $clog2(p_tick + 1);

    localparam logic [IW-1:0]    IDX_ONE  = IW'(1);
    localparam logic [IW-1:0]    DEPTH_R  = IW'(p_depth);
    localparam logic [AW-1:0]    FILL_END = AW'(p_depth - 1);
    localparam logic [CW-1:0]    TICK_END = CW'(p_tick - 1);
    localparam logic [3:0]       TIME_MAX = 4'(p_time);
    localparam logic [p_key-1:0] KEY_ONE  = p_key'(1);

    game_state_t state, state_n;

    logic [AW-1:0]    fill_idx, fill_n;
    logic [AW-1:0]    idx, idx_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [CW-1:0]    tick_cnt, tick_n;
    logic [IW-1:0]    round_n;
    logic [7:0]       points_n;
    logic [3:0]       time_n;
    logic             end_fpga_n, end_user_n, match_n, end_time_n, win_n;
    logic [p_key-1:0] key_prev, fall, expect_onehot;
    logic [KW-1:0]    seq_mem [0:p_depth-1];
    logic [KW-1:0]    cur_key, rnd;
    logic [CW-1:0]    on_len, off_len;
    logic             lfsr_en, seq_we;

    game_lfsr #(.p_out(KW)) u_lfsr (
        .clk  (CLOCK_50),
        .load (R),
        .seed (p_seed),
        .en   (lfsr_en),
        .rnd  (rnd)
    );

    assign on_len        = CW'(p_tick) >> speed;
    assign off_len       = CW'(p_tick) >> ({1'b0, speed} + 3'd2);
    assign cur_key       = seq_mem[idx];
    assign expect_onehot = KEY_ONE << cur_key;
    assign fall          = key_prev & ~KEY;
    assign leds          = (state == SHOW_ON) ? expect_onehot : '0;
    assign busy          = !(state == IDLE || state == WIN || state == LOSE);

    always_ff @(posedge CLOCK_50) begin
        if (seq_we)
            seq_mem[fill_idx] <= rnd;
    end

    always_ff @(posedge CLOCK_50) begin
        if (R) begin
            state    <= IDLE;
            fill_idx <= '0;
            idx      <= '0;
            cnt      <= '0;
            tick_cnt <= '0;
            ROUND    <= '0;
            POINTS   <= 8'h00;
            TIME     <= 4'd0;
            end_FPGA <= 1'b0;
            end_User <= 1'b0;
            match    <= 1'b0;
            end_time <= 1'b0;
            win      <= 1'b0;
            key_prev <= '1;
        end else begin
            state    <= state_n;
            fill_idx <= fill_n;
            idx      <= idx_n;
            cnt      <= cnt_n;
            tick_cnt <= tick_n;
            ROUND    <= round_n;
            POINTS   <= points_n;
            TIME     <= time_n;
            end_FPGA <= end_fpga_n;
            end_User <= end_user_n;
            match    <= match_n;
            end_time <= end_time_n;
            win      <= win_n;
            key_prev <= KEY;
        end
    end

    // Press handling outranks the timeout, which outranks the 1 s tick.
    always_comb begin
        state_n    = state;
        fill_n     = fill_idx;
        idx_n      = idx;
        cnt_n      = cnt;
        tick_n     = tick_cnt;
        round_n    = ROUND;
        points_n   = POINTS;
        time_n     = TIME;
        end_fpga_n = 1'b0;
        end_user_n = 1'b0;
        match_n    = 1'b0;
        end_time_n = end_time;
        win_n      = win;
        lfsr_en    = 1'b0;
        seq_we     = 1'b0;

        case (state)
            IDLE, WIN, LOSE: begin
                lfsr_en = (state == IDLE);
                if (start) begin
                    state_n    = FILL;
                    fill_n     = '0;
                    points_n   = 8'h00;
                    time_n     = 4'd0;
                    round_n    = IDX_ONE;
                    end_time_n = 1'b0;
                    win_n      = 1'b0;
                end
            end
            FILL: begin
                lfsr_en = 1'b1;
                seq_we  = 1'b1;
                if (fill_idx == FILL_END) begin
                    state_n = SHOW_ON;
                    idx_n   = '0;
                    cnt_n   = '0;
                end else begin
                    fill_n = fill_idx + AW'(1);
                end
            end
            SHOW_ON: begin
                if (cnt == on_len - CW'(1)) begin
                    state_n = SHOW_OFF;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            SHOW_OFF: begin
                if (cnt == off_len - CW'(1)) begin
                    cnt_n = '0;
                    if ((IW'(idx) + IDX_ONE) < ROUND) begin
                        idx_n   = idx + AW'(1);
                        state_n = SHOW_ON;
                    end else begin
                        end_fpga_n = 1'b1;
                        idx_n      = '0;
                        time_n     = 4'd0;
                        tick_n     = '0;
                        state_n    = WAIT;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            WAIT: begin
                if (fall != '0) begin
                    if (fall == expect_onehot) begin
                        match_n  = 1'b1;
                        points_n = bcd_inc_sat(POINTS);
                        time_n   = 4'd0;
                        tick_n   = '0;
                        if ((IW'(idx) + IDX_ONE) == ROUND) begin
                            if (ROUND == DEPTH_R) begin
                                win_n   = 1'b1;
                                state_n = WIN;
                            end else begin
                                end_user_n = 1'b1;
                                round_n    = ROUND + IDX_ONE;
                                idx_n      = '0;
                                cnt_n      = '0;
                                state_n    = SHOW_ON;
                            end
                        end else begin
                            idx_n = idx + AW'(1);
                        end
                    end else begin
                        state_n = LOSE;
                    end
                end else if (TIME == TIME_MAX) begin
                    end_time_n = 1'b1;
                    state_n    = LOSE;
                end else if (tick_cnt == TICK_END) begin
                    tick_n = '0;
                    time_n = TIME + 4'd1;
                end else begin
                    tick_n = tick_cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_seq_game_engine.sv
// Self-checking bench for seq_game_engine: models the LFSR fill independently and
// scoreboards the expected POINTS value of every accepted press.
module tb_seq_game_engine;

    localparam int          P_KEY   = 4;
    localparam int          P_DEPTH = 4;
    localparam int          P_TICK  = 16;
    localparam int          P_TIME  = 3;
    localparam logic [15:0] P_SEED  = 16'hACE1;

    logic             clk = 1'b0;
    logic             R, start;
    logic [1:0]       speed;
    logic [P_KEY-1:0] KEY;
    logic [P_KEY-1:0] leds;
    logic [2:0]       ROUND;
    logic [7:0]       POINTS;
    logic [3:0]       TIME;
    logic             end_FPGA, end_User, match, end_time, win, busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_press = 0;
    int n_match = 0;
    int n_end_user = 0;
    logic [7:0] exp_q [$];

    logic [15:0] m_lfsr;
    logic [1:0]  m_seq [P_DEPTH];
    int          m_phase = 0;
    int          m_fill = 0;

    seq_game_engine #(
        .p_key   (P_KEY),
        .p_depth (P_DEPTH),
        .p_tick  (P_TICK),
        .p_time  (P_TIME),
        .p_seed  (P_SEED)
    ) dut (
        .CLOCK_50 (clk),
        .R        (R),
        .start    (start),
        .speed    (speed),
        .KEY      (KEY),
        .leds     (leds),
        .ROUND    (ROUND),
        .POINTS   (POINTS),
        .TIME     (TIME),
        .end_FPGA (end_FPGA),
        .end_User (end_User),
        .match    (match),
        .end_time (end_time),
        .win      (win),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] n;
        n = v >> 1;
        if (v[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        return 8'(((n / 10) << 4) | (n % 10));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Reference sequence generator: steps in IDLE, fills for p_depth cycles after start.
    always @(posedge clk) begin
        if (R) begin
            m_lfsr  = P_SEED;
            m_phase = 0;
        end else begin
            case (m_phase)
                0: begin
                    m_lfsr = lfsr_step(m_lfsr);
                    if (start) begin
                        m_phase = 1;
                        m_fill  = 0;
                    end
                end
                1: begin
                    m_seq[m_fill] = m_lfsr[1:0];
                    m_lfsr = lfsr_step(m_lfsr);
                    m_fill++;
                    if (m_fill == P_DEPTH) m_phase = 2;
                end
                default: begin
                    if (start) begin
                        m_phase = 1;
                        m_fill  = 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (match === 1'b1) begin
            n_match++;
            if (exp_q.size() == 0)
                checkOutput("spurious_match", match, 1'b0);
            else
                checkOutput("match_points", POINTS, exp_q.pop_front());
        end
        if (end_User === 1'b1) n_end_user++;
    end

    task automatic applyStimulus(input logic [P_KEY-1:0] mask, input bit good);
        @(posedge clk);
        #1 KEY = ~mask;
        if (good) begin
            n_press++;
            exp_q.push_back(to_bcd(n_press));
        end
        @(posedge clk);
        #1 KEY = '1;
    endtask

    task automatic start_game();
        n_press = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checkOutput("start_points", POINTS, 8'h00);
        checkOutput("start_round", ROUND, 3'd1);
        checkOutput("start_time", TIME, 4'd0);
        checkOutput("start_flags", {win, end_time}, 2'b00);
        checkOutput("start_busy", busy, 1'b1);
        repeat (4) @(posedge clk);
    endtask

    task automatic check_playback(input int r);
        int   bad_on = 0;
        int   bad_off = 0;
        logic eu_first = 1'b0;
        for (int j = 0; j < r; j++) begin
            for (int c = 0; c < P_TICK; c++) begin
                @(negedge clk);
                if (j == 0 && c == 0) eu_first = end_User;
                if (leds !== (4'b0001 << m_seq[j]) || end_FPGA !== 1'b0) bad_on++;
            end
            for (int c = 0; c < P_TICK / 4; c++) begin
                @(negedge clk);
                if (leds !== 4'b0000 || end_FPGA !== 1'b0) bad_off++;
            end
        end
        checkOutput("leds_lit", bad_on, 0);
        checkOutput("leds_dark", bad_off, 0);
        checkOutput("end_user_at_show", eu_first, (r > 1));
        @(negedge clk);
        checkOutput("end_fpga", end_FPGA, 1'b1);
        checkOutput("wait_round", ROUND, r);
        checkOutput("wait_time", TIME, 4'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] wk;
        R = 1'b1;
        start = 1'b0;
        speed = 2'd0;
        KEY = '1;
        repeat (2) @(posedge clk);
        #1 R = 1'b0;
        @(negedge clk);
        checkOutput("reset_leds", leds, 4'b0000);
        checkOutput("reset_round", ROUND, 3'd0);
        checkOutput("reset_points", POINTS, 8'h00);
        checkOutput("reset_time", TIME, 4'd0);
        checkOutput("reset_flags", {busy, win, end_time, match, end_User, end_FPGA}, 6'b0);

        $display("[TB] game 1: correct presses to win");
        start_game();
        for (int r = 1; r <= P_DEPTH; r++) begin
            check_playback(r);
            for (int j = 0; j < r; j++) applyStimulus(4'b0001 << m_seq[j], 1'b1);
        end
        @(negedge clk);
        #1;
        checkOutput("win_level", win, 1'b1);
        checkOutput("win_busy", busy, 1'b0);
        checkOutput("win_points", POINTS, 8'h10);
        checkOutput("win_match_count", n_match, 10);
        checkOutput("win_end_user_count", n_end_user, 3);
        checkOutput("win_queue_empty", exp_q.size(), 0);

        $display("[TB] game 2: wrong key in round 2");
        start_game();
        check_playback(1);
        applyStimulus(4'b0001 << m_seq[0], 1'b1);
        check_playback(2);
        applyStimulus(4'b0001 << m_seq[0], 1'b1);
        wk = m_seq[1] + 2'd1;
        applyStimulus(4'b0001 << wk, 1'b0);
        @(negedge clk);
        checkOutput("wrong_busy", busy, 1'b0);
        checkOutput("wrong_win", win, 1'b0);
        checkOutput("wrong_end_time", end_time, 1'b0);
        checkOutput("wrong_points", POINTS, 8'h02);

        $display("[TB] game 3: timeout");
        start_game();
        check_playback(1);
        for (int off = 1; off <= 49; off++) begin
            @(negedge clk);
            if (off == 15) checkOutput("time_before_tick", TIME, 4'd0);
            if (off == 16) checkOutput("time_1", TIME, 4'd1);
            if (off == 32) checkOutput("time_2", TIME, 4'd2);
            if (off == 48) begin
                checkOutput("time_3", TIME, 4'd3);
                checkOutput("end_time_early", end_time, 1'b0);
            end
            if (off == 49) begin
                checkOutput("end_time", end_time, 1'b1);
                checkOutput("timeout_busy", busy, 1'b0);
                checkOutput("timeout_time_hold", TIME, 4'd3);
            end
        end

        $display("[TB] game 4: two keys at once");
        start_game();
        check_playback(1);
        wk = m_seq[0] + 2'd1;
        applyStimulus((4'b0001 << m_seq[0]) | (4'b0001 << wk), 1'b0);
        @(negedge clk);
        checkOutput("dual_busy", busy, 1'b0);
        checkOutput("dual_flags", {win, end_time}, 2'b00);
        checkOutput("dual_points", POINTS, 8'h00);

        $display("[TB] game 5: held key, then reset mid-playback");
        start_game();
        #1 KEY = ~(4'b0001 << m_seq[0]);
        check_playback(1);
        repeat (5) @(negedge clk);
        checkOutput("held_busy", busy, 1'b1);
        checkOutput("held_points", POINTS, 8'h00);
        @(posedge clk);
        #1 KEY = '1;
        applyStimulus(4'b0001 << m_seq[0], 1'b1);
        R = 1'b1;
        @(negedge clk);
        checkOutput("leds_before_reset", leds, 4'b0001 << m_seq[0]);
        checkOutput("round_before_reset", ROUND, 3'd2);
        @(posedge clk);
        #1 R = 1'b0;
        @(negedge clk);
        checkOutput("midreset_leds", leds, 4'b0000);
        checkOutput("midreset_round", ROUND, 3'd0);
        checkOutput("midreset_points", POINTS, 8'h00);
        checkOutput("midreset_flags", {busy, win, end_time, match, end_User, end_FPGA}, 6'b0);
        checkOutput("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
